// File: rtl/bpf_fwd.sv
// ============================================================================
// Module   : bpf_fwd
// Purpose  : Forwarding stage after the BPF core. Streams accepted packets out
//            of packet memory as 32-bit valid/ready beats; pulses fwd_done to
//            release the buffer. Optional macro FWD_STATS_EN adds verdict
//            counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpf_fwd #(
    parameter int SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int PLEN_WIDTH           = SNOOP_FWD_ADDR_WIDTH + 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_acc,
    input  logic                            cpu_rej,
    input  logic [PLEN_WIDTH-1:0]           packet_len,
    output logic                            fwd_rd_en,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0] fwd_rd_addr,
    input  logic [31:0]                     fwd_rd_data,
    output logic [31:0]                     fwd_data,
    output logic [3:0]                      fwd_keep,
    output logic                            fwd_last,
    output logic                            fwd_valid,
    input  logic                            fwd_ready,
    output logic                            fwd_done
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                     stat_acc_count,
    output logic [31:0]                     stat_rej_count
`endif
);

    localparam int CW = PLEN_WIDTH - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   last_idx_q, last_idx_d;
    logic [1:0]      tail_q, tail_d;
    logic            issued_all_q, issued_all_d;

    logic            pend_q;
    logic [3:0]      pend_keep_q;
    logic            pend_last_q;

    logic [31:0]     fifo_data_q [2];
    logic [3:0]      fifo_keep_q [2];
    logic            fifo_last_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      fifo_cnt_q, fifo_cnt_d;

    logic [PLEN_WIDTH-1:0] len_m1;
    logic            rd_en;
    logic            is_last_word;
    logic [3:0]      tail_keep;
    logic [3:0]      issue_keep;
    logic            head_valid;
    logic [31:0]     head_data;
    logic [3:0]      head_keep;
    logic            head_last;
    logic            pop;
    logic            stored_pop;
    logic            push;

    // len-1 gives both the last word index and the byte position in that word
    assign len_m1       = packet_len - 1'b1;
    assign is_last_word = (cnt_q == last_idx_q);

    always_comb begin
        tail_keep = 4'b1111;
        case (tail_q)
            2'd0:    tail_keep = 4'b1000;
            2'd1:    tail_keep = 4'b1100;
            2'd2:    tail_keep = 4'b1110;
            default: tail_keep = 4'b1111;
        endcase
    end

    assign issue_keep = is_last_word ? tail_keep : 4'b1111;

    // Returned data and stored entries together never exceed two slots
    assign rd_en = (state_q == S_SEND) && !issued_all_q &&
                   ((fifo_cnt_q + {1'b0, pend_q}) < 2'd2);

    // Data returning this cycle counts as an entry and can bypass to the output
    always_comb begin
        head_valid = (fifo_cnt_q != 2'd0) || pend_q;
        head_data  = '0;
        head_keep  = '0;
        head_last  = 1'b0;
        if (fifo_cnt_q != 2'd0) begin
            head_data = fifo_data_q[rd_ptr_q];
            head_keep = fifo_keep_q[rd_ptr_q];
            head_last = fifo_last_q[rd_ptr_q];
        end else if (pend_q) begin
            head_data = fwd_rd_data;
            head_keep = pend_keep_q;
            head_last = pend_last_q;
        end
    end

    assign pop        = head_valid && fwd_ready;
    assign stored_pop = pop && (fifo_cnt_q != 2'd0);
    assign push       = pend_q && !(pop && (fifo_cnt_q == 2'd0));
    assign fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, stored_pop};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_idx_d   = last_idx_q;
        tail_d       = tail_q;
        issued_all_d = issued_all_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_rej) begin
                    state_d = S_DONE;
                end else if (cpu_acc) begin
                    if (packet_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_SEND;
                        cnt_d        = '0;
                        issued_all_d = 1'b0;
                        last_idx_d   = len_m1[PLEN_WIDTH-1:2];
                        tail_d       = len_m1[1:0];
                    end
                end
            end
            S_SEND: begin
                if (rd_en) begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_last_word) begin
                        issued_all_d = 1'b1;
                    end
                end
                if (pop && head_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_idx_q   <= '0;
            tail_q       <= '0;
            issued_all_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_keep_q  <= '0;
            pend_last_q  <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_cnt_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_keep_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_idx_q   <= last_idx_d;
            tail_q       <= tail_d;
            issued_all_q <= issued_all_d;
            pend_q       <= rd_en;
            pend_keep_q  <= issue_keep;
            pend_last_q  <= is_last_word;
            fifo_cnt_q   <= fifo_cnt_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= fwd_rd_data;
                fifo_keep_q[wr_ptr_q] <= pend_keep_q;
                fifo_last_q[wr_ptr_q] <= pend_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (stored_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign fwd_rd_en   = rd_en;
    assign fwd_rd_addr = cnt_q[SNOOP_FWD_ADDR_WIDTH-1:0];
    assign fwd_valid   = head_valid;
    assign fwd_data    = head_data;
    assign fwd_keep    = head_keep;
    assign fwd_last    = head_last;
    assign fwd_done    = (state_q == S_DONE);

`ifdef FWD_STATS_EN
    logic [31:0] stat_acc_q, stat_rej_q;

    // A simultaneous accept and reject is counted as a reject
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_acc_q <= '0;
            stat_rej_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (cpu_rej) begin
                if (stat_rej_q != 32'hFFFF_FFFF) begin
                    stat_rej_q <= stat_rej_q + 32'd1;
                end
            end else if (cpu_acc) begin
                if (stat_acc_q != 32'hFFFF_FFFF) begin
                    stat_acc_q <= stat_acc_q + 32'd1;
                end
            end
        end
    end

    assign stat_acc_count = stat_acc_q;
    assign stat_rej_count = stat_rej_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bpf_fwd.sv
// ============================================================================
// Module   : tb_bpf_fwd
// Purpose  : Self-checking bench for bpf_fwd with a packet-level reference
//            model (expected beats from memory contents and packet length).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bpf_fwd;

    localparam int AW = 9;
    localparam int PW = AW + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_acc = 1'b0;
    logic          cpu_rej = 1'b0;
    logic [PW-1:0] packet_len = '0;
    logic          fwd_rd_en;
    logic [AW-1:0] fwd_rd_addr;
    logic [31:0]   fwd_rd_data = '0;
    logic [31:0]   fwd_data;
    logic [3:0]    fwd_keep;
    logic          fwd_last;
    logic          fwd_valid;
    logic          fwd_ready = 1'b1;
    logic          fwd_done;
`ifdef FWD_STATS_EN
    logic [31:0]   stat_acc_count;
    logic [31:0]   stat_rej_count;
`endif

    bpf_fwd #(.SNOOP_FWD_ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_acc     (cpu_acc),
        .cpu_rej     (cpu_rej),
        .packet_len  (packet_len),
        .fwd_rd_en   (fwd_rd_en),
        .fwd_rd_addr (fwd_rd_addr),
        .fwd_rd_data (fwd_rd_data),
        .fwd_data    (fwd_data),
        .fwd_keep    (fwd_keep),
        .fwd_last    (fwd_last),
        .fwd_valid   (fwd_valid),
        .fwd_ready   (fwd_ready),
        .fwd_done    (fwd_done)
`ifdef FWD_STATS_EN
        ,
        .stat_acc_count (stat_acc_count),
        .stat_rej_count (stat_rej_count)
`endif
    );

    always #5 clk = ~clk;

    // Packet memory model: one-cycle read latency
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (fwd_rd_en) fwd_rd_data <= mem[fwd_rd_addr];
    end

    int     n_checks = 0;
    int     n_fail   = 0;
    longint model_acc = 0;
    longint model_rej = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_keep(input int len, input int i);
        int n = (len + 3) / 4;
        if (i < n - 1) return 4'hF;
        case (len % 4)
            0:       return 4'b1111;
            1:       return 4'b1000;
            2:       return 4'b1100;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic longint sat_inc(input longint v);
        return (v < 64'hFFFF_FFFF) ? v + 1 : v;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    endtask

    task automatic check_stats();
`ifdef FWD_STATS_EN
        check_val("stat_acc", stat_acc_count, model_acc[31:0]);
        check_val("stat_rej", stat_rej_count, model_rej[31:0]);
`endif
    endtask

    // Reject, simultaneous acc+rej, or zero-length accept: done at t+1 only
    task automatic verdict_only(input bit acc, input bit rej, input int len);
        @(negedge clk);
        cpu_acc = acc;
        cpu_rej = rej;
        packet_len = PW'(len);
        if (rej) model_rej = sat_inc(model_rej);
        else     model_acc = sat_inc(model_acc);
        @(negedge clk);
        cpu_acc = 1'b0;
        cpu_rej = 1'b0;
        #1;
        check_val("vd_done_t1", fwd_done, 1'b1);
        check_val("vd_valid", fwd_valid, 1'b0);
        check_val("vd_rd_en", fwd_rd_en, 1'b0);
        @(negedge clk);
        #1;
        check_val("vd_done_t2", fwd_done, 1'b0);
        check_val("vd_valid2", fwd_valid, 1'b0);
        check_val("vd_rd_en2", fwd_rd_en, 1'b0);
        check_stats();
    endtask

    // rmode: 0 ready high, 1 ready toggling, 2 random ready plus stray verdicts
    task automatic send_pkt(input int len, input int rmode, input int rst_after);
        int n = (len + 3) / 4;
        int rd_next = 0;
        int popped = 0;
        int k = 0;
        int budget = 20 * n + 20;
        bit prev_stall = 1'b0;
        bit saw_valid = 1'b0;
        bit pend_done = 1'b0;
        bit finished = 1'b0;
        logic [31:0] hd = '0;
        logic [3:0]  hk = '0;
        logic        hl = 1'b0;

        fill_mem();
        @(negedge clk);
        cpu_acc = 1'b1;
        packet_len = PW'(len);
        model_acc = sat_inc(model_acc);

        while (k < budget && !finished) begin
            @(negedge clk);
            k++;
            cpu_acc = 1'b0;
            cpu_rej = 1'b0;
            if (pend_done) begin
                #1;
                check_val("done_after_last", fwd_done, 1'b1);
                check_val("done_valid", fwd_valid, 1'b0);
                if (rmode == 0) check_val("done_cycle", k, n + 2);
                finished = 1'b1;
            end else begin
                case (rmode)
                    0:       fwd_ready = 1'b1;
                    1:       fwd_ready = (k % 2 == 0);
                    default: begin
                        fwd_ready = 1'($urandom_range(0, 1));
                        cpu_acc = ($urandom_range(0, 7) == 0);
                        cpu_rej = ($urandom_range(0, 7) == 0);
                        packet_len = PW'($urandom_range(0, 40));
                    end
                endcase
                #1;
                check_val("done_early", fwd_done, 1'b0);
                if (fwd_rd_en) begin
                    check_val("rd_addr", fwd_rd_addr, rd_next);
                    rd_next++;
                    check_val("outstanding_le2", (rd_next - popped) <= 2, 1'b1);
                    check_val("rd_in_range", rd_next <= n, 1'b1);
                end
                if (prev_stall) check_val("hold_valid", fwd_valid, 1'b1);
                if (fwd_valid) begin
                    if (!saw_valid && rmode == 0) check_val("first_valid_lat", k, 2);
                    saw_valid = 1'b1;
                    if (prev_stall) begin
                        check_val("hold_data", fwd_data, hd);
                        check_val("hold_keep", fwd_keep, hk);
                        check_val("hold_last", fwd_last, hl);
                    end
                    check_val("beat_in_range", popped < n, 1'b1);
                    if (popped < n) begin
                        check_val("beat_data", fwd_data, mem[popped]);
                        check_val("beat_keep", fwd_keep, exp_keep(len, popped));
                        check_val("beat_last", fwd_last, popped == n - 1);
                    end
                    hd = fwd_data;
                    hk = fwd_keep;
                    hl = fwd_last;
                    prev_stall = !fwd_ready;
                    if (fwd_ready) begin
                        popped++;
                        if (rmode == 0) check_val("beat_cycle", k, popped + 1);
                        if (popped >= n) pend_done = 1'b1;
                        if (rst_after > 0 && popped == rst_after) begin
                            @(negedge clk);
                            rst = 1'b1;
                            @(negedge clk);
                            #1;
                            check_val("rst_rd_en", fwd_rd_en, 1'b0);
                            check_val("rst_rd_addr", fwd_rd_addr, 0);
                            check_val("rst_valid", fwd_valid, 1'b0);
                            check_val("rst_data", fwd_data, 0);
                            check_val("rst_keep", fwd_keep, 0);
                            check_val("rst_last", fwd_last, 1'b0);
                            check_val("rst_done", fwd_done, 1'b0);
                            rst = 1'b0;
                            model_acc = 0;
                            model_rej = 0;
                            for (int j = 0; j < 4; j++) begin
                                @(negedge clk);
                                #1;
                                check_val("post_rst_done", fwd_done, 1'b0);
                                check_val("post_rst_valid", fwd_valid, 1'b0);
                            end
                            finished = 1'b1;
                        end
                    end
                end else begin
                    prev_stall = 1'b0;
                end
            end
        end
        check_val("pkt_completed", finished, 1'b1);
        cpu_acc = 1'b0;
        cpu_rej = 1'b0;
        fwd_ready = 1'b1;
        check_stats();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_rd_en", fwd_rd_en, 1'b0);
        check_val("reset_valid", fwd_valid, 1'b0);
        check_val("reset_last", fwd_last, 1'b0);
        check_val("reset_done", fwd_done, 1'b0);
        check_val("reset_rd_addr", fwd_rd_addr, 0);
        check_val("reset_data", fwd_data, 0);
        check_val("reset_keep", fwd_keep, 0);
        check_stats();
        rst = 1'b0;

        send_pkt(10, 0, 0);
        verdict_only(1'b0, 1'b1, 12);
        send_pkt(16, 1, 0);
        verdict_only(1'b1, 1'b0, 0);
        verdict_only(1'b1, 1'b1, 20);
        send_pkt(64, 0, 2);
        send_pkt(5, 0, 0);
        send_pkt(1, 0, 0);
        send_pkt(7, 1, 0);

        for (int it = 0; it < 40; it++) begin
            int r = $urandom_range(0, 5);
            int len = $urandom_range(0, 40);
            if (r == 0)         verdict_only(1'b0, 1'b1, len);
            else if (r == 1)    verdict_only(1'b1, 1'b1, len);
            else if (len == 0)  verdict_only(1'b1, 1'b0, 0);
            else                send_pkt(len, (r == 2) ? 0 : 2, 0);
        end

`ifdef FWD_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_acc = 0;
        model_rej = 0;
        for (int i = 0; i < 3; i++) verdict_only(1'b1, 1'b0, 0);
        for (int i = 0; i < 2; i++) verdict_only(1'b0, 1'b1, 0);
        check_val("stat_acc_3", stat_acc_count, 32'd3);
        check_val("stat_rej_2", stat_rej_count, 32'd2);
        @(negedge clk);
        force dut.stat_acc_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.stat_acc_q;
        model_acc = 64'hFFFF_FFFF;
        verdict_only(1'b1, 1'b0, 0);
        check_val("stat_acc_sat", stat_acc_count, 32'hFFFF_FFFF);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
